// File: rtl/spi_shift_controller.sv
// SPI mode-0 master sequencer for an external parallel-load/serial-shift register.
// Each accepted start loads the register, runs WIDTH sclk periods with cs_n low
// (MSB first, miso shifted in at each sclk fall) and then captures the received word.
module spi_shift_controller #(
    parameter int WIDTH   = 8,
    parameter int CLK_DIV = 2
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_tx_data,
    input  logic             i_abort,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_rx_data,
    output logic             o_sr_enable,
    output logic [WIDTH-1:0] o_sr_data_in,
    output logic             o_sr_shift_enable,
    output logic             o_sr_shift_in,
    input  logic [WIDTH-1:0] i_sr_data_out,
    input  logic             i_sr_shift_out,
    output logic             o_sclk,
    output logic             o_cs_n,
    output logic             o_mosi,
    input  logic             i_miso
);

    localparam int PW = $clog2(CLK_DIV + 1);
    localparam int BW = $clog2(WIDTH + 1);
    localparam logic [PW-1:0] PH_LAST  = PW'(CLK_DIV - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_LEAD,
        ST_HIGH,
        ST_LOW,
        ST_TRAIL,
        ST_DONE
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [PW-1:0]    r_phase;
    logic [BW-1:0]    r_bit_cnt;
    logic             w_phase_last;
    logic             r_sclk;
    logic             r_cs_n;
    logic             r_done;
    logic [WIDTH-1:0] r_rx_data;
    logic [WIDTH-1:0] r_sr_data_in;

    assign w_phase_last = (r_phase == PH_LAST);

    // State register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode; abort overrides every transition out of a non-idle state.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:  if (i_start) w_next = ST_LOAD;
            ST_LOAD:  w_next = ST_LEAD;
            ST_LEAD:  if (w_phase_last) w_next = ST_HIGH;
            ST_HIGH:  if (w_phase_last) w_next = (r_bit_cnt == BIT_LAST) ? ST_TRAIL : ST_LOW;
            ST_LOW:   if (w_phase_last) w_next = ST_HIGH;
            ST_TRAIL: if (w_phase_last) w_next = ST_DONE;
            ST_DONE:  w_next = ST_IDLE;
            default:  w_next = ST_IDLE;
        endcase
        if (i_abort && (r_state != ST_IDLE)) begin
            w_next = ST_IDLE;
        end
    end

    // Phase counter restarts on every state change and saturates at its last value.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_phase <= '0;
        end else if (w_next != r_state) begin
            r_phase <= '0;
        end else if (!w_phase_last) begin
            r_phase <= r_phase + PW'(1);
        end
    end

    // Bit counter advances at the end of each HIGH phase and clears while idle.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_bit_cnt <= '0;
        end else if (r_state == ST_IDLE) begin
            r_bit_cnt <= '0;
        end else if ((r_state == ST_HIGH) && w_phase_last) begin
            r_bit_cnt <= r_bit_cnt + BW'(1);
        end
    end

    // Pin-level outputs are registered from the next state so they switch cleanly with it.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sclk <= 1'b0;
            r_cs_n <= 1'b1;
            r_done <= 1'b0;
        end else begin
            r_sclk <= (w_next == ST_HIGH);
            r_cs_n <= !((w_next == ST_LEAD) || (w_next == ST_HIGH) ||
                        (w_next == ST_LOW)  || (w_next == ST_TRAIL));
            r_done <= (w_next == ST_DONE);
        end
    end

    // Received word is captured as DONE is entered and held until the next completion.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rx_data <= '0;
        end else if (w_next == ST_DONE) begin
            r_rx_data <= i_sr_data_out;
        end
    end

    // Transmit word is latched only when a start is accepted.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sr_data_in <= '0;
        end else if ((r_state == ST_IDLE) && i_start) begin
            r_sr_data_in <= i_tx_data;
        end
    end

    assign o_busy            = (r_state != ST_IDLE);
    assign o_done            = r_done;
    assign o_rx_data         = r_rx_data;
    assign o_sr_enable       = (r_state == ST_LOAD);
    assign o_sr_data_in      = r_sr_data_in;
    assign o_sr_shift_enable = (r_state == ST_HIGH) && w_phase_last;
    assign o_sr_shift_in     = i_miso;
    assign o_sclk            = r_sclk;
    assign o_cs_n            = r_cs_n;
    assign o_mosi            = r_cs_n ? 1'b0 : i_sr_shift_out;

endmodule

// File: doc/spi_shift_controller.md
Name: spi_shift_controller

Overview:
- Sequencer for the parallel-load/serial-shift register in the SPI examples.
- Handles one transfer per start request:
  - parallel-loads the transmit word into the shift register;
  - generates cs_n and a divided serial clock (SPI mode 0, MSB first);
  - steps the register once per bit, using miso as its serial input;
  - captures the received word and pulses done.
- Sits between user logic (start/busy/done handshake) and one shift register instance plus the SPI pins.

Parameters:
- WIDTH, 8: bits per transfer. Must match the shift register WIDTH. Minimum 1.
- CLK_DIV, 2: system clock cycles per sclk half-period. Minimum 1.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset.
- start  in  1  transfer request. Sampled only in IDLE.
- tx_data  in  WIDTH  word to transmit. Sampled on the same edge as start.
- abort  in  1  cancels an in-progress transfer.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when rx_data is updated.
- rx_data  out  WIDTH  last completed received word. Held until the next completion.
- sr_enable  out  1  to shift register enable (parallel load).
- sr_data_in  out  WIDTH  to shift register data_in.
- sr_shift_enable  out  1  to shift register shift_enable.
- sr_shift_in  out  1  to shift register shift_in. Combinational copy of miso.
- sr_data_out  in  WIDTH  from shift register data_out.
- sr_shift_out  in  1  from shift register shift_out (MSB).
- sclk  out  1  SPI clock. Idles low.
- cs_n  out  1  SPI chip select, active low.
- mosi  out  1  equals sr_shift_out while cs_n=0, else 0.
- miso  in  1  SPI data in.

Behaviour:
- Clock and reset:
  - One clock; reset is asynchronous and active-low.
  - All registers reset on rst_n low, independent of clk.
- Reset values:
  - busy=0, done=0, rx_data=0, sr_enable=0, sr_data_in=0, sr_shift_enable=0, sclk=0, cs_n=1.
  - FSM in IDLE, phase counter and bit counter cleared.
  - Reset mid-transfer gives the same result immediately. No done pulse is produced.
- Registered outputs: sclk, cs_n, done, rx_data, sr_data_in.
  - sr_enable and sr_shift_enable are decoded from state/counter.
- States:
  - IDLE:
    - cs_n=1, sclk=0.
    - start=1 → LOAD; tx_data latched into sr_data_in.
  - LOAD (1 cycle):
    - sr_enable=1.
    - → LEAD.
  - LEAD (CLK_DIV cycles):
    - cs_n=0, sclk=0, so mosi shows the MSB.
    - → HIGH.
  - HIGH (CLK_DIV cycles):
    - sclk=1.
    - In the last cycle, sr_shift_enable=1, which shifts miso in and presents the next mosi bit as sclk falls.
    - bit_cnt increments at the end of the phase.
    - If bit_cnt was WIDTH-1 → TRAIL, else → LOW.
  - LOW (CLK_DIV cycles):
    - sclk=0.
    - → HIGH.
  - TRAIL (CLK_DIV cycles):
    - sclk=0, cs_n=0.
    - → DONE.
  - DONE (1 cycle):
    - cs_n=1.
    - done=1; rx_data ← sr_data_out.
    - → IDLE.
- Timing (edge 0 is the edge that samples start):
  - DONE is entered at edge 1+CLK_DIV*(2*WIDTH+1).
  - Exactly WIDTH sclk rising edges and WIDTH sr_shift_enable cycles per transfer.
- start:
  - Ignored while busy=1, including the DONE cycle.
  - start in the first IDLE cycle after DONE is accepted, giving back-to-back transfers.
- abort:
  - Has priority over all transitions.
  - In any non-IDLE state: next edge → IDLE, cs_n=1, sclk=0, no done pulse, rx_data unchanged.
  - Shift register contents are left as-is.
  - abort in IDLE has no effect. abort together with start in IDLE: start wins.
- Counters:
  - bit_cnt is $clog2(WIDTH+1) bits wide.
  - Phase counter is $clog2(CLK_DIV+1) bits wide and reloads at every state change. No wrap-around beyond its terminal value.
- Edge cases:
  - CLK_DIV=1: sclk toggles every cycle and sr_shift_enable is asserted every HIGH cycle.
  - WIDTH=1: a single HIGH phase, then TRAIL.

Test Plan:
- WIDTH=8, CLK_DIV=2, miso tied to mosi, start with tx_data=0xA5 → mosi MSB-first 1,0,1,0,0,1,0,1 on successive sclk rises; done at edge 35; rx_data=0xA5; cs_n high again at edge 35.
- Slave model returns 0x3C while tx_data=0x81 → rx_data=0x3C; exactly 8 sclk rising edges; sr_enable high for exactly 1 cycle (edge 0–1).
- start pulsed with tx_data=0xFF during an in-progress 0x12 transfer → ignored; result reflects 0x12 only; busy stays high continuously.
- abort asserted after the 4th sclk rising edge → IDLE next edge; cs_n=1; sclk=0; no done; rx_data keeps its previous value; a new start then completes normally.
- rst_n pulsed low asynchronously mid-HIGH phase → all outputs at reset values before the next clk edge; rx_data=0.
- CLK_DIV=1: start 0x5A, then start 0xC3 in the first IDLE cycle after done → two done pulses 19 edges apart (done at edge 18 of each transfer, +1 IDLE cycle); rx_data sequence matches the slave words.
